// File: rtl/postproc_pkg.sv
// rtl/postproc_pkg.sv - shared constants, helpers and sample type for the post-processing chain
package postproc_pkg;

  localparam int SAMPLE_DATA_W = 16;

  typedef struct packed {
    logic [SAMPLE_DATA_W-1:0] data;
    logic                     last;
  } sample_t;

  function automatic int gain_unity(input int frac);
    return 1 << frac;
  endfunction

  // Right shift that maps a log-width x gain-width product onto the display code width
  function automatic int sh_amount(input int log_w, input int gain_frac, input int comp_w);
    return gain_frac + log_w - comp_w;
  endfunction

endpackage

// File: rtl/pp_round_sat.sv
// rtl/pp_round_sat.sv - combinational round-half-up right shift with saturation to OUT_W bits
module pp_round_sat #(
  parameter int IN_W  = 28,
  parameter int SH    = 16,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [OUT_W-1:0] o_data,
  output logic             o_clip
);

  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SH - 1);

  // One extra bit so adding the rounding constant can never wrap
  logic [IN_W:0] w_sum;
  logic [IN_W:0] w_shr;

  assign w_sum  = {1'b0, i_data} + HALF;
  assign w_shr  = w_sum >> SH;
  assign o_clip = |w_shr[IN_W:OUT_W];
  assign o_data = o_clip ? '1 : w_shr[OUT_W-1:0];

endmodule

// File: rtl/postproc_dr.sv
// rtl/postproc_dr.sv - post-log dynamic-range compressor: offset, gain, round/saturate, 3 stages
// Clip statistics outputs exist only when POSTPROC_DR_CLIP_CNT_EN is defined.
module postproc_dr
  import postproc_pkg::*;
#(
  parameter int LOG_WIDTH      = 16,
  parameter int COMP_WIDTH     = 8,
  parameter int GAIN_WIDTH     = 12,
  parameter int GAIN_FRAC      = 8,
  parameter int CLIP_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOG_WIDTH-1:0]  log_in,
  input  logic                  in_last,
  input  logic                  cfg_load,
  input  logic [GAIN_WIDTH-1:0] cfg_gain,
  input  logic [LOG_WIDTH-1:0]  cfg_offset,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COMP_WIDTH-1:0] comp_out,
  output logic                  out_last
`ifdef POSTPROC_DR_CLIP_CNT_EN
  ,
  output logic [CLIP_CNT_WIDTH-1:0] clip_cnt,
  output logic                      clip_flag
`endif
);

  localparam int PROD_W = LOG_WIDTH + GAIN_WIDTH;
  localparam int SH     = sh_amount(LOG_WIDTH, GAIN_FRAC, COMP_WIDTH);
  localparam logic [GAIN_WIDTH-1:0] GAIN_ONE = GAIN_WIDTH'(gain_unity(GAIN_FRAC));

  logic [GAIN_WIDTH-1:0] r_gain;
  logic [LOG_WIDTH-1:0]  r_offset;

  logic                  r_v1, r_v2, r_v3;
  logic [LOG_WIDTH-1:0]  r1_d;
  logic [GAIN_WIDTH-1:0] r1_gain;
  logic                  r1_last;
  logic [PROD_W-1:0]     r2_p;
  logic                  r2_last;
  logic [COMP_WIDTH-1:0] r3_code;
  logic                  r3_last;

  logic                  w_ld1, w_ld2, w_ld3;
  logic [LOG_WIDTH-1:0]  w_diff;
  logic [PROD_W-1:0]     w_prod;
  logic [COMP_WIDTH-1:0] w_code;
  logic                  w_clip;

  // A stage may load when it is empty or its contents move on this cycle
  assign w_ld3    = !r_v3 || out_ready;
  assign w_ld2    = !r_v2 || w_ld3;
  assign w_ld1    = !r_v1 || w_ld2;
  assign in_ready = w_ld1;

  assign w_diff = (log_in >= r_offset) ? (log_in - r_offset) : '0;
  assign w_prod = PROD_W'(r1_d) * PROD_W'(r1_gain);

  pp_round_sat #(
    .IN_W  (PROD_W),
    .SH    (SH),
    .OUT_W (COMP_WIDTH)
  ) u_round_sat (
    .i_data (r2_p),
    .o_data (w_code),
    .o_clip (w_clip)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gain   <= GAIN_ONE;
      r_offset <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r1_d     <= '0;
      r1_gain  <= '0;
      r1_last  <= 1'b0;
      r2_p     <= '0;
      r2_last  <= 1'b0;
      r3_code  <= '0;
      r3_last  <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_gain   <= cfg_gain;
        r_offset <= cfg_offset;
      end
      if (w_ld1) begin
        r_v1    <= in_valid;
        r1_d    <= w_diff;
        r1_gain <= r_gain;
        r1_last <= in_last;
      end
      if (w_ld2) begin
        r_v2    <= r_v1;
        r2_p    <= w_prod;
        r2_last <= r1_last;
      end
      if (w_ld3) begin
        r_v3    <= r_v2;
        r3_code <= w_code;
        r3_last <= r2_last;
      end
    end
  end

  assign out_valid = r_v3;
  assign comp_out  = r3_code;
  assign out_last  = r3_last;

`ifdef POSTPROC_DR_CLIP_CNT_EN
  logic r3_clip;
  logic w_clip_xfer;

  assign w_clip_xfer = r_v3 && out_ready && r3_clip;

  always_ff @(posedge clk) begin
    if (reset) begin
      r3_clip   <= 1'b0;
      clip_cnt  <= '0;
      clip_flag <= 1'b0;
    end else begin
      if (w_ld3) r3_clip <= w_clip;
      // A clip coinciding with cfg_load is the first clip of the new configuration
      if (cfg_load) begin
        clip_cnt  <= CLIP_CNT_WIDTH'(w_clip_xfer);
        clip_flag <= w_clip_xfer;
      end else if (w_clip_xfer) begin
        if (~&clip_cnt) clip_cnt <= clip_cnt + 1'b1;
        clip_flag <= 1'b1;
      end
    end
  end
`else
  localparam int unused_clip_cnt_width = CLIP_CNT_WIDTH;
  logic w_unused_clip;
  assign w_unused_clip = w_clip;
`endif

endmodule

// File: tb/tb_postproc_dr.sv
// tb/tb_postproc_dr.sv - scoreboard bench for postproc_dr (clip checks under POSTPROC_DR_CLIP_CNT_EN)
module tb_postproc_dr;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] log_in = '0;
  logic        in_last = 1'b0;
  logic        cfg_load = 1'b0;
  logic [11:0] cfg_gain = '0;
  logic [15:0] cfg_offset = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  comp_out;
  logic        out_last;
`ifdef POSTPROC_DR_CLIP_CNT_EN
  logic [15:0] clip_cnt;
  logic        clip_flag;
`endif

  postproc_dr dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .log_in     (log_in),
    .in_last    (in_last),
    .cfg_load   (cfg_load),
    .cfg_gain   (cfg_gain),
    .cfg_offset (cfg_offset),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .comp_out   (comp_out),
    .out_last   (out_last)
`ifdef POSTPROC_DR_CLIP_CNT_EN
    ,
    .clip_cnt   (clip_cnt),
    .clip_flag  (clip_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   tb_gain = 'h100;
  int   tb_off = 0;
  bit   rand_en = 1'b0;
  bit   ready_level = 1'b1;

  int   occ = 0;
  bit   prev_stall = 1'b0;
  int   prev_code = 0;
  bit   prev_last = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model(input int x, input int g, input int o);
    longint d, r;
    d = (x > o) ? longint'(x - o) : 64'd0;
    r = (d * g + 32768) >> 16;
    return (r > 255) ? 255 : int'(r);
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Monitor: stability, in_ready and ordered scoreboard checks
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      occ = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_code", int'(comp_out), prev_code);
        chk("hold_last", int'(out_last), int'(prev_last));
      end
      chk("in_ready", int'(in_ready), int'(!(occ == 3 && !out_ready)));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_output: got 0x%0h, expected no output", comp_out);
        end else begin
          e = exp_q.pop_front();
          chk("comp_out", int'(comp_out), e.code);
          chk("out_last", int'(out_last), int'(e.last));
        end
      end
      occ = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      prev_code = int'(comp_out);
      prev_last = out_last;
    end
  end

  task automatic send(input int x, input bit last, input int exp);
    exp_t e;
    int t;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b1;
    log_in = x[15:0];
    in_last = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e.code = exp;
        e.last = last;
        exp_q.push_back(e);
        break;
      end
      t++;
      if (t > 1000) begin
        n_chk++;
        n_err++;
        $display("FAIL send_timeout: got in_ready=0, expected acceptance of 0x%0h", x);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cfg(input int x, input int exp, input int g, input int o);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    log_in = x[15:0];
    in_last = 1'b0;
    cfg_load = 1'b1;
    cfg_gain = g[11:0];
    cfg_offset = o[15:0];
    @(negedge clk);
    chk("cfg_accept_ready", int'(in_ready), 1);
    e.code = exp;
    e.last = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b0;
    tb_gain = g;
    tb_off = o;
  endtask

  task automatic do_cfg(input int g, input int o);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_load = 1'b1;
    cfg_gain = g[11:0];
    cfg_offset = o[15:0];
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    tb_gain = g;
    tb_off = o;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cfg_load = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    idle(1);
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_comp_out", int'(comp_out), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Unity defaults and exact 3-cycle latency
    send('hABCD, 1'b0, 'hAC);
    idle(1);
    @(negedge clk);
    chk("lat_cycle1", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle3", int'(out_valid), 1);
    send('hAB7F, 1'b0, 'hAB);
    send('hFFFF, 1'b0, 'hFF);
    drain();

    // Sample accepted with cfg_load uses the old configuration
    send_cfg('hABCD, 'hAC, 'h200, 0);
    send('h4000, 1'b0, 'h80);
    drain();

    do_cfg('h100, 'h2000);
    send('h1000, 1'b0, 'h00);
    send('h3080, 1'b0, 'h11);
    drain();

    do_cfg('h200, 0);
    send('h4000, 1'b0, 'h80);
    send('h9000, 1'b1, 'hFF);
    drain();
`ifdef POSTPROC_DR_CLIP_CNT_EN
    @(negedge clk);
    chk("clip_cnt_one", int'(clip_cnt), 1);
    chk("clip_flag_set", int'(clip_flag), 1);
    do_cfg('h200, 0);
    @(negedge clk);
    chk("clip_cnt_clr", int'(clip_cnt), 0);
    chk("clip_flag_clr", int'(clip_flag), 0);
`endif

    // Long stream under random backpressure
    do_cfg('h180, 'h1000);
    rand_en = 1'b1;
    for (int i = 0; i < 100; i++)
      send(i * 655, (i == 99), model(i * 655, tb_gain, tb_off));
    drain();
    rand_en = 1'b0;
    ready_level = 1'b1;

    // Config change while three samples are stalled in flight
    ready_level = 1'b0;
    idle(3);
    do_cfg('h100, 0);
    send('h5000, 1'b0, 'h50);
    send('h6000, 1'b0, 'h60);
    send('h7000, 1'b0, 'h70);
    idle(1);
    @(negedge clk);
    chk("full_in_ready", int'(in_ready), 0);
    do_cfg('h080, 0);
    ready_level = 1'b1;
    send('h5000, 1'b0, 'h28);
    send('h6000, 1'b1, 'h30);
    drain();

    // Reset with a full, stalled pipeline
    do_cfg('h200, 'h100);
    ready_level = 1'b0;
    idle(3);
    send('h1000, 1'b0, model('h1000, tb_gain, tb_off));
    send('h2000, 1'b0, model('h2000, tb_gain, tb_off));
    send('h3000, 1'b0, model('h3000, tb_gain, tb_off));
    idle(1);
    @(negedge clk);
    chk("prerst_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tb_gain = 'h100;
    tb_off = 0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    ready_level = 1'b1;
    idle(1);
    send('hABCD, 1'b0, 'hAC);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
